ps2_rx_port: RTL and testbench

- Receive-only PS/2 keyboard port, running in the pixel clock domain.
- Synchronises and deglitches the raw PS/2 clock and data pins, then deframes 11-bit device-to-host frames.
- Presents each received scan-code byte on a single-entry valid/ready output.
- Sits between the board PS/2 pins and the character-writer logic that stores bytes into video RAM.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_pin_filter.sv | 77 +++++++
 rtl/ps2_rx_port.sv | 154 +++++++++++++++
 tb/tb_ps2_rx_port.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive port.
// Build option: PS2_RX_PARITY_CHECK_EN enables odd-parity qualification.
package ps2_pkg;

    localparam logic LOW  = 1'b0;
    localparam logic HIGH = 1'b1;
    localparam logic YES  = 1'b1;
    localparam logic NO   = 1'b0;

    localparam int FRAME_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Odd parity holds when data plus parity bit carry an odd ones-count.
    function automatic logic odd_parity_ok(
        input logic [FRAME_DATA_BITS-1:0] data,
        input logic                       par
    );
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_pin_filter.sv
// Two-flop synchroniser, optional stability filter and falling-edge strobe
// for one PS/2 pin.
module ps2_pin_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter bit FILTER_EN  = 1'b1
) (
    input  logic clk,
    input  logic reset_low,
    input  logic pin_i,
    output logic level_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       synced;
    logic       level;
    logic       prev_q;

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            sync_q <= {HIGH, HIGH};
        end else begin
            sync_q <= {sync_q[0], pin_i};
        end
    end

    assign synced = sync_q[1];

    if (FILTER_EN) begin : g_filter
        localparam int CW = $clog2(FILTER_LEN + 1);

        logic [CW-1:0] cnt_q, cnt_d;
        logic          filt_q, filt_d;

        // Level flips only after FILTER_LEN samples that all disagree with it.
        always_comb begin
            cnt_d  = cnt_q;
            filt_d = filt_q;
            if (synced == filt_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                cnt_d  = '0;
                filt_d = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset_low) begin
            if (!reset_low) begin
                cnt_q  <= '0;
                filt_q <= HIGH;
            end else begin
                cnt_q  <= cnt_d;
                filt_q <= filt_d;
            end
        end

        assign level = filt_q;
    end else begin : g_nofilter
        assign level = synced;
    end

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            prev_q <= HIGH;
        end else begin
            prev_q <= level;
        end
    end

    assign level_o = level;
    assign fall_o  = prev_q & ~level;

endmodule

// File: rtl/ps2_rx_port.sv
// Receive-only PS/2 port: deframes 11-bit frames into a one-entry byte output.
// Build option: PS2_RX_PARITY_CHECK_EN drops frames with bad odd parity.
module ps2_rx_port
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 148500
) (
    input  logic       clk,
    input  logic       reset_low,
    input  logic       ps2_clk_pin,
    input  logic       ps2_data_pin,
    input  logic       rx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data
);

`ifdef PS2_RX_PARITY_CHECK_EN
    localparam logic PARITY_CHECK = YES;
`else
    localparam logic PARITY_CHECK = NO;
`endif

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic strobe;
    logic data_s;
    logic unused_data_fall;

    ps2_pin_filter #(
        .FILTER_LEN (FILTER_LEN),
        .FILTER_EN  (1'b1)
    ) u_clk_filt (
        .clk       (clk),
        .reset_low (reset_low),
        .pin_i     (ps2_clk_pin),
        .level_o   (),
        .fall_o    (strobe)
    );

    ps2_pin_filter #(
        .FILTER_LEN (FILTER_LEN),
        .FILTER_EN  (1'b0)
    ) u_data_sync (
        .clk       (clk),
        .reset_low (reset_low),
        .pin_i     (ps2_data_pin),
        .level_o   (data_s),
        .fall_o    (unused_data_fall)
    );

    rx_state_e                  state_q, state_d;
    logic [2:0]                 bit_cnt_q, bit_cnt_d;
    logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
    logic                       parity_q, parity_d;
    logic [TW-1:0]              tmo_q, tmo_d;
    logic                       rx_valid_q, rx_valid_d;
    logic [7:0]                 rx_data_q, rx_data_d;
    logic                       accept;
    logic                       parity_pass;

    assign parity_pass = (PARITY_CHECK == NO)
                       || odd_parity_ok(shift_q, parity_q);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tmo_d     = tmo_q;
        accept    = NO;

        unique case (state_q)
            IDLE: begin
                if (strobe && data_s == LOW) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (strobe) begin
                    shift_d[bit_cnt_q] = data_s;
                    if (bit_cnt_q == 3'(FRAME_DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (strobe) begin
                    parity_d = data_s;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (strobe) begin
                    accept  = (data_s == HIGH) && parity_pass;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled device must not wedge the deframer mid-frame.
        if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (strobe) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_d   = '0;
            state_d = IDLE;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_comb begin
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = NO;
        end
        // Slot free or emptying this edge; otherwise the new byte is lost.
        if (accept && (!rx_valid_q || rx_ready)) begin
            rx_valid_d = YES;
            rx_data_d  = shift_q;
        end
    end

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= LOW;
            tmo_q      <= '0;
            rx_valid_q <= NO;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tmo_q      <= tmo_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_ps2_rx_port.sv
// Directed bench for ps2_rx_port with a byte scoreboard on the output port.
module tb_ps2_rx_port;

    logic       clk = 1'b0;
    logic       reset_low = 1'b0;
    logic       ps2_clk_pin = 1'b1;
    logic       ps2_data_pin = 1'b1;
    logic       rx_ready = 1'b0;
    logic       rx_valid;
    logic [7:0] rx_data;

    int checks = 0;
    int failures = 0;
    int xfers = 0;
    int valid_cycles = 0;
    logic [7:0] sb_q[$];

    ps2_rx_port #(
        .FILTER_LEN     (2),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk          (clk),
        .reset_low    (reset_low),
        .ps2_clk_pin  (ps2_clk_pin),
        .ps2_data_pin (ps2_data_pin),
        .rx_ready     (rx_ready),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transfers happen on the next rising edge; sample midway.
    always @(negedge clk) begin
        if (reset_low && rx_valid) valid_cycles++;
        if (reset_low && rx_valid && rx_ready) begin
            xfers++;
            checks++;
            if (sb_q.size() == 0) begin
                assert (0) else begin
                    failures++;
                    $error("FAIL unexpected_byte observed=%0h expected=none",
                           rx_data);
                end
            end else begin
                logic [7:0] e;
                e = sb_q.pop_front();
                assert (rx_data === e) else begin
                    failures++;
                    $error("FAIL sb_byte observed=%0h expected=%0h",
                           rx_data, e);
                end
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bits go out start, D0..D7, parity, stop; nbits truncates the frame.
    task automatic send(input logic [7:0] d, input bit bad_par,
                        input int nbits);
        logic [10:0] f;
        f = {1'b1, ~^d ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data_pin = f[i];
            clks(10);
            ps2_clk_pin = 1'b0;
            clks(20);
            ps2_clk_pin = 1'b1;
            clks(10);
        end
        ps2_data_pin = 1'b1;
    endtask

    initial begin
        int x0;
        logic held;

        clks(3);
        chk("reset_valid", rx_valid, 0);
        chk("reset_data", rx_data, 0);
        reset_low = 1'b1;
        clks(5);

        // Key 'A' with ready high: single one-cycle pulse
        rx_ready = 1'b1;
        valid_cycles = 0;
        sb_q.push_back(8'h1C);
        send(8'h1C, 0, 11);
        clks(20);
        chk("a_pulse_cycles", valid_cycles, 1);
        chk("a_sb_empty", sb_q.size(), 0);
        chk("a_data_held", rx_data, 8'h1C);

        // Back-pressure
        rx_ready = 1'b0;
        sb_q.push_back(8'hF0);
        send(8'hF0, 0, 11);
        held = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (!(rx_valid === 1'b1 && rx_data === 8'hF0)) held = 1'b0;
            clks(1);
        end
        chk("bp_held", held, 1);
        rx_ready = 1'b1;
        clks(1);
        chk("bp_valid_drop", rx_valid, 0);
        chk("bp_sb_empty", sb_q.size(), 0);

        // Overflow: second byte dropped
        rx_ready = 1'b0;
        sb_q.push_back(8'h1C);
        send(8'h1C, 0, 11);
        send(8'h32, 0, 11);
        clks(20);
        chk("ovf_valid", rx_valid, 1);
        chk("ovf_data", rx_data, 8'h1C);
        x0 = xfers;
        rx_ready = 1'b1;
        clks(50);
        chk("ovf_one_xfer", xfers - x0, 1);
        chk("ovf_valid_low", rx_valid, 0);

        // Parity error frame, then good frame
`ifndef PS2_RX_PARITY_CHECK_EN
        sb_q.push_back(8'h1C);
`endif
        send(8'h1C, 1, 11);
        clks(20);
        sb_q.push_back(8'h29);
        send(8'h29, 0, 11);
        clks(20);
        chk("par_sb_empty", sb_q.size(), 0);
        chk("par_last", rx_data, 8'h29);

        // Timeout: stall after four data bits
        send(8'hFF, 0, 5);
        clks(1100);
        sb_q.push_back(8'h45);
        send(8'h45, 0, 11);
        clks(20);
        chk("tmo_sb_empty", sb_q.size(), 0);
        chk("tmo_data", rx_data, 8'h45);

        // One-cycle clock glitch in IDLE with data low
        ps2_data_pin = 1'b0;
        clks(5);
        ps2_clk_pin = 1'b0;
        clks(1);
        ps2_clk_pin = 1'b1;
        clks(5);
        ps2_data_pin = 1'b1;
        clks(50);
        sb_q.push_back(8'h3C);
        send(8'h3C, 0, 11);
        clks(20);
        chk("glitch_sb_empty", sb_q.size(), 0);
        chk("glitch_data", rx_data, 8'h3C);

        // Async reset mid-frame with a byte pending
        rx_ready = 1'b0;
        send(8'h11, 0, 11);
        clks(20);
        chk("rst_pre_valid", rx_valid, 1);
        send(8'h77, 0, 4);
        @(posedge clk);
        #3;
        reset_low = 1'b0;
        #1;
        chk("rst_async_valid", rx_valid, 0);
        chk("rst_async_data", rx_data, 0);
        clks(4);
        reset_low = 1'b1;
        clks(10);
        rx_ready = 1'b1;
        sb_q.push_back(8'h5A);
        send(8'h5A, 0, 11);
        clks(20);
        chk("rst_sb_empty", sb_q.size(), 0);
        chk("rst_data", rx_data, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
